// File: rtl/fp_pkg.sv
// Shared constants and encoding helpers for the parameterised float datapath blocks.
// Encodings are built at a fixed wide width and narrowed by the caller to EXP+FRA+1 bits.
package fp_pkg;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UDF = 0;
  localparam int FLG_W   = 3;

  typedef logic [FLG_W-1:0] flag_t;

  localparam int ENC_W = 64;
  typedef logic [ENC_W-1:0] enc_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic enc_t fp_zero(input logic sign, input int exp_w, input int fra_w);
    return enc_t'(sign) << (exp_w + fra_w);
  endfunction

  function automatic enc_t fp_inf(input logic sign, input int exp_w, input int fra_w);
    return fp_zero(sign, exp_w, fra_w) | (((enc_t'(1) << exp_w) - enc_t'(1)) << fra_w);
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the top fraction bit set.
  function automatic enc_t fp_qnan(input int exp_w, input int fra_w);
    return fp_inf(1'b0, exp_w, fra_w) | (enc_t'(1) << (fra_w - 1));
  endfunction

endpackage

// File: rtl/fp_cmult_if.sv
// Operand/result bundle of the float multiplier: qualified operands in, registered result and status out.
interface fp_cmult_if #(
  parameter int EXP = 5,
  parameter int FRA = 10
);
  import fp_pkg::*;

  localparam int W = EXP + FRA + 1;

  logic         valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Y;
  flag_t        flag;

  modport master (output valid, output A, output B, input Y, input flag);
  modport slave  (input valid, input A, input B, output Y, output flag);

endinterface

// File: rtl/fp_round.sv
// Normalise a raw mantissa product, round to nearest-even and clamp to Inf/zero.
// Purely combinational so it can sit inside any float pipeline stage.
module fp_round
  import fp_pkg::*;
#(
  parameter  int EXP = 5,
  parameter  int FRA = 10,
  localparam int W   = EXP + FRA + 1,
  localparam int PW  = 2 * (FRA + 1),
  localparam int EW  = EXP + 2
) (
  input  logic          sign_i,
  input  logic [EW-1:0] exp_i,
  input  logic [PW-1:0] prod_i,
  output logic [W-1:0]  y_o,
  output logic          ovf_o,
  output logic          udf_o
);

  localparam logic [W-1:0] INF_P  = W'(fp_inf(1'b0, EXP, FRA));
  localparam logic [W-1:0] ZERO_P = W'(fp_zero(1'b0, EXP, FRA));
  localparam logic [EXP:0] E_TOP  = (EXP + 1)'((1 << EXP) - 1);

  logic          msb;
  logic [PW-2:0] norm;
  logic [FRA-1:0] frac;
  logic          rnd;
  logic          sticky;
  logic          inc;
  logic [FRA:0]  mant;
  logic [EW-1:0] e_fin;

  always_comb begin
    msb    = prod_i[PW-1];
    // Drop the hidden bit so the fraction always starts right below it.
    norm   = msb ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
    frac   = norm[PW-2 -: FRA];
    rnd    = norm[PW-2-FRA];
    sticky = |norm[PW-3-FRA:0];
    inc    = rnd & (sticky | frac[0]);
    mant   = {1'b0, frac} + (FRA + 1)'(inc);
    e_fin  = exp_i + EW'(msb) + EW'(mant[FRA]);

    ovf_o  = !e_fin[EW-1] && (e_fin[EXP:0] >= E_TOP);
    udf_o  = e_fin[EW-1] || (e_fin == '0);

    if (ovf_o) begin
      y_o = {sign_i, INF_P[W-2:0]};
    end else if (udf_o) begin
      y_o = {sign_i, ZERO_P[W-2:0]};
    end else begin
      y_o = {sign_i, e_fin[EXP-1:0], mant[FRA-1:0]};
    end
  end

endmodule

// File: rtl/fp_cmult.sv
// Floating-point multiplier with one registered stage; denormal inputs read as signed zero.
// Result and status hold until the next qualified operand pair.
module fp_cmult
  import fp_pkg::*;
#(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic       aclk,
  input  logic       aresetn,
  fp_cmult_if.slave  bus
);

  localparam int W    = EXP + FRA + 1;
  localparam int PW   = 2 * (FRA + 1);
  localparam int EW   = EXP + 2;
  localparam int BIAS = fp_bias(EXP);

  localparam logic [W-1:0] QNAN   = W'(fp_qnan(EXP, FRA));
  localparam logic [W-1:0] INF_P  = W'(fp_inf(1'b0, EXP, FRA));
  localparam logic [W-1:0] ZERO_P = W'(fp_zero(1'b0, EXP, FRA));

  logic [W-1:0]   opnd    [2];
  logic [EXP-1:0] op_exp  [2];
  logic [FRA:0]   op_mant [2];
  logic [1:0]     op_sign;
  logic [1:0]     op_nan;
  logic [1:0]     op_inf;
  logic [1:0]     op_zero;

  assign opnd[0] = bus.A;
  assign opnd[1] = bus.B;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_sign[gi] = opnd[gi][W-1];
      assign op_exp[gi]  = opnd[gi][W-2 -: EXP];
      assign op_mant[gi] = {1'b1, opnd[gi][FRA-1:0]};
      assign op_inf[gi]  = (&op_exp[gi]) && (opnd[gi][FRA-1:0] == '0);
      assign op_nan[gi]  = (&op_exp[gi]) && (opnd[gi][FRA-1:0] != '0);
      assign op_zero[gi] = (op_exp[gi] == '0);
    end
  endgenerate

  logic          sign_y;
  logic [EW-1:0] exp_sum;
  logic [PW-1:0] prod;
  logic [W-1:0]  rnd_y;
  logic          rnd_ovf;
  logic          rnd_udf;

  assign sign_y  = ^op_sign;
  // Widened so both the overflow and the negative underflow bound stay representable.
  assign exp_sum = EW'(op_exp[0]) + EW'(op_exp[1]) - EW'(BIAS);
  assign prod    = PW'(op_mant[0]) * PW'(op_mant[1]);

  fp_round #(
    .EXP (EXP),
    .FRA (FRA)
  ) u_round (
    .sign_i (sign_y),
    .exp_i  (exp_sum),
    .prod_i (prod),
    .y_o    (rnd_y),
    .ovf_o  (rnd_ovf),
    .udf_o  (rnd_udf)
  );

  logic [W-1:0] y_d,    y_q;
  flag_t        flag_d, flag_q;
  logic         invalid;

  assign invalid = (|op_nan) || (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]);

  always_comb begin
    y_d    = rnd_y;
    flag_d = '0;
    if (invalid) begin
      y_d             = QNAN;
      flag_d[FLG_INV] = 1'b1;
    end else if (|op_inf) begin
      y_d = {sign_y, INF_P[W-2:0]};
    end else if (|op_zero) begin
      y_d = {sign_y, ZERO_P[W-2:0]};
    end else begin
      flag_d[FLG_OVF] = rnd_ovf;
      flag_d[FLG_UDF] = rnd_udf;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      y_q    <= '0;
      flag_q <= '0;
    end else if (bus.valid) begin
      y_q    <= y_d;
      flag_q <= flag_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.flag = flag_q;

endmodule

// File: tb/tb_fp_cmult.sv
// Bench for fp_cmult (binary16): directed corner cases, then a random stream against an integer model.
module tb_fp_cmult;

  logic aclk = 1'b0;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;

  always #5 aclk = ~aclk;

  fp_cmult_if #(.EXP(5), .FRA(10)) bus ();

  fp_cmult #(.EXP(5), .FRA(10)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of the significands, then RNE by remainder vs half.
  function automatic logic [18:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, e, sh;
    longint p, q, r, half;
    logic s, na, nb, ia, ib, za, zb;
    logic [15:0] y;
    logic [2:0] f;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);  eb = int'(b[14:10]);
    fa = int'(a[9:0]);    fb = int'(b[9:0]);
    na = (ea == 31) && (fa != 0);  nb = (eb == 31) && (fb != 0);
    ia = (ea == 31) && (fa == 0);  ib = (eb == 31) && (fb == 0);
    za = (ea == 0);                zb = (eb == 0);
    f  = 3'b000;
    if (na || nb || (ia && zb) || (ib && za)) begin
      y = 16'h7E00;
      f = 3'b100;
    end else if (ia || ib) begin
      y = {s, 5'h1F, 10'h000};
    end else if (za || zb) begin
      y = {s, 15'h0000};
    end else begin
      p  = longint'(1024 + fa) * longint'(1024 + fb);
      e  = ea + eb - 15;
      sh = 10;
      if (p >= (longint'(1) << 21)) begin
        sh = 11;
        e  = e + 1;
      end
      q    = p >> sh;
      r    = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
      if (q == 2048) begin
        q = 1024;
        e = e + 1;
      end
      if (e >= 31) begin
        y = {s, 5'h1F, 10'h000};
        f = 3'b010;
      end else if (e <= 0) begin
        y = {s, 15'h0000};
        f = 3'b001;
      end else begin
        y = {s, 5'(e), 10'(q)};
      end
    end
    return {f, y};
  endfunction

  function automatic logic [15:0] gen_op(input int mode);
    logic [15:0] tbl [8];
    tbl = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E01, 16'h0123, 16'h3C00, 16'h7BFF};
    case (mode)
      0:       return 16'($urandom);
      1:       return {1'($urandom), 5'($urandom_range(22, 8)), 10'($urandom)};
      2:       return {1'($urandom), 5'($urandom_range(20, 10)), 5'($urandom), 5'h00};
      default: return tbl[$urandom_range(7, 0)];
    endcase
  endfunction

  task automatic run_dir(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ey, input logic [2:0] ef);
    @(negedge aclk);
    bus.A = a;  bus.B = b;  bus.valid = 1'b1;
    @(negedge aclk);
    bus.valid = 1'b0;
    $display("txn %h*%h y=%h flag=%b", a, b, bus.Y, bus.flag);
    chk($sformatf("y_%h_%h", a, b), 32'(bus.Y), 32'(ey));
    chk($sformatf("flag_%h_%h", a, b), 32'(bus.flag), 32'(ef));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [18:0] exp_r;
    logic [15:0] a, b;
    logic        v, have;

    aresetn = 1'b0;  bus.valid = 1'b1;  bus.A = 16'h3C00;  bus.B = 16'h3C00;
    repeat (5) @(negedge aclk);
    $display("txn reset y=%h flag=%b", bus.Y, bus.flag);
    chk("reset_y", 32'(bus.Y), 32'h0000);
    chk("reset_flag", 32'(bus.flag), 32'h0);
    aresetn = 1'b1;  bus.valid = 1'b0;

    run_dir(16'h2E66, 16'h2E66, 16'h211E, 3'b000);
    bus.A = 16'h3C00;  bus.B = 16'h4000;
    repeat (2) @(negedge aclk);
    $display("txn hold y=%h flag=%b", bus.Y, bus.flag);
    chk("hold_y", 32'(bus.Y), 32'h211E);
    chk("hold_flag", 32'(bus.flag), 32'h0);

    run_dir(16'h3C00, 16'h4000, 16'h4000, 3'b000);
    run_dir(16'hBC00, 16'h4000, 16'hC000, 3'b000);
    run_dir(16'h3E00, 16'h3E00, 16'h4080, 3'b000);
    run_dir(16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010);
    run_dir(16'h0400, 16'h0400, 16'h0000, 3'b001);
    run_dir(16'h7C00, 16'h0000, 16'h7E00, 3'b100);
    run_dir(16'h7C00, 16'hC000, 16'hFC00, 3'b000);
    run_dir(16'h8000, 16'h3C00, 16'h8000, 3'b000);

    // Reset must win over a simultaneous valid.
    @(negedge aclk);
    aresetn = 1'b0;  bus.valid = 1'b1;  bus.A = 16'h3C00;  bus.B = 16'h4000;
    @(negedge aclk);
    $display("txn reset_prio y=%h flag=%b", bus.Y, bus.flag);
    chk("rst_prio_y", 32'(bus.Y), 32'h0000);
    aresetn = 1'b1;  bus.valid = 1'b0;

    exp_r = 19'h0;
    have  = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge aclk);
      if (have) begin
        $display("txn stream %0d y=%h flag=%b exp_y=%h exp_flag=%b",
                 i, bus.Y, bus.flag, exp_r[15:0], exp_r[18:16]);
        chk($sformatf("stream_y_%0d", i), 32'(bus.Y), 32'(exp_r[15:0]));
        chk($sformatf("stream_flag_%0d", i), 32'(bus.flag), 32'(exp_r[18:16]));
      end
      if (i < 119) begin
        v = (i % 13) != 12;
        if (v) begin
          a     = gen_op(int'($urandom_range(3, 0)));
          b     = gen_op(int'($urandom_range(3, 0)));
          exp_r = ref_mul(a, b);
          bus.A = a;
          bus.B = b;
        end else begin
          bus.A = 16'($urandom);
          bus.B = 16'($urandom);
        end
        bus.valid = v;
        have      = 1'b1;
      end
    end
    bus.valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
